// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Holds the FSM state encoding, sweep-order selectors and the Gray mapping.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int ORDER_BIN  = 0;
   localparam int ORDER_GRAY = 1;

   // Sized to the widest supported stim; callers truncate to their width.
   function automatic logic [15:0] bin2gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/tt_sweep_checker_bin2gray.sv
// Combinational binary-to-Gray encoder used to order the sweep so that
// exactly one DUT input toggles between consecutive vectors.
module bin2gray_enc
   import tt_sweep_pkg::*;
#(
   parameter int W = 3
) (
   input  logic [W-1:0] i_bin,
   output logic [W-1:0] o_gray
);

   assign o_gray = W'(bin2gray(16'(i_bin)));

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker: walks every input vector into a small
// combinational DUT, waits SETTLE cycles, and compares dut_o against TRUTH.
module tt_sweep_checker
   import tt_sweep_pkg::*;
#(
   parameter int                    N_IN   = 3,
   parameter logic [(1<<N_IN)-1:0]  TRUTH  = 8'hEA,
   parameter int                    SETTLE = 1,
   parameter int                    ORDER  = ORDER_BIN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] stim,
   input  logic            dut_o,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic            first_err_vld,
   output logic [N_IN-1:0] first_err_vec
);

   localparam int              SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};

   state_t          r_state;
   logic [N_IN-1:0] r_idx;
   logic [SW-1:0]   r_settle;
   logic [N_IN-1:0] r_stim;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [N_IN:0]   r_err_cnt;
   logic            r_fev;
   logic [N_IN-1:0] r_fvec;

   logic [N_IN-1:0] w_next_idx;
   logic [N_IN-1:0] w_next_stim;
   logic            w_exp;
   logic            w_mis;
   logic            w_last;
   logic            w_start_ok;

   assign w_next_idx = r_idx + 1'b1;
   assign w_last     = (r_idx == LAST_IDX);
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // Expected value is looked up by the vector actually driven, so the
   // sweep order never affects which TRUTH bit is used.
   assign w_exp = TRUTH[r_stim];
   assign w_mis = (dut_o !== w_exp);

   generate
      if (ORDER == ORDER_GRAY) begin : g_gray
         bin2gray_enc #(
            .W (N_IN)
         ) u_enc (
            .i_bin  (w_next_idx),
            .o_gray (w_next_stim)
         );
      end else begin : g_bin
         assign w_next_stim = w_next_idx;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_settle  <= '0;
         r_stim    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_err_cnt <= '0;
         r_fev     <= 1'b0;
         r_fvec    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  // Both orders map index 0 to vector 0.
                  r_state   <= S_HOLD;
                  r_idx     <= '0;
                  r_stim    <= '0;
                  r_settle  <= SETTLE_LD;
                  r_err_cnt <= '0;
                  r_fev     <= 1'b0;
                  r_fvec    <= '0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
               end
            end

            S_HOLD: begin
               if (r_settle != '0) begin
                  r_settle <= r_settle - 1'b1;
               end else begin
                  r_state <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (w_mis) begin
                  r_err_cnt <= r_err_cnt + 1'b1;
                  if (!r_fev) begin
                     r_fev  <= 1'b1;
                     r_fvec <= r_stim;
                  end
               end
               if (w_last) begin
                  // Final verdict includes this last comparison.
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_cnt == '0) && !w_mis;
               end else begin
                  r_state  <= S_HOLD;
                  r_idx    <= w_next_idx;
                  r_stim   <= w_next_stim;
                  r_settle <= SETTLE_LD;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stim          = r_stim;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign err_cnt       = r_err_cnt;
   assign first_err_vld = r_fev;
   assign first_err_vec = r_fvec;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Randomised self-checking bench: three checker instances (binary, Gray,
// slow settle) driven by table-based DUT models and compared to a sweep model.
module tb_tt_sweep_checker;

   localparam logic [7:0] GOLD = 8'hEA;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   int         sel;
   logic [7:0] tab;
   bit         dly;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   logic       st_b, st_g, st_s;
   logic [2:0] stim_b, stim_g, stim_s;
   logic       o_b, o_g, o_s;
   logic       busy_b, busy_g, busy_s;
   logic       done_b, done_g, done_s;
   logic       pass_b, pass_g, pass_s;
   logic [3:0] err_b, err_g, err_s;
   logic       fev_b, fev_g, fev_s;
   logic [2:0] fvec_b, fvec_g, fvec_s;
   logic [2:0] d1_b, d2_b, d1_g, d2_g, d1_s, d2_s;

   assign st_b = start && (sel == 0);
   assign st_g = start && (sel == 1);
   assign st_s = start && (sel == 2);

   // DUT models: a lookup table, optionally seen through a 2-cycle delay.
   always @(posedge clk) begin
      d1_b <= stim_b; d2_b <= d1_b;
      d1_g <= stim_g; d2_g <= d1_g;
      d1_s <= stim_s; d2_s <= d1_s;
   end
   assign o_b = dly ? tab[d2_b] : tab[stim_b];
   assign o_g = dly ? tab[d2_g] : tab[stim_g];
   assign o_s = dly ? tab[d2_s] : tab[stim_s];

   tt_sweep_checker #(.N_IN(3), .TRUTH(GOLD), .SETTLE(1), .ORDER(0)) u_bin (
      .clk(clk), .rst_n(rst_n), .start(st_b), .stim(stim_b), .dut_o(o_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
      .first_err_vld(fev_b), .first_err_vec(fvec_b));

   tt_sweep_checker #(.N_IN(3), .TRUTH(GOLD), .SETTLE(1), .ORDER(1)) u_gray (
      .clk(clk), .rst_n(rst_n), .start(st_g), .stim(stim_g), .dut_o(o_g),
      .busy(busy_g), .done(done_g), .pass(pass_g), .err_cnt(err_g),
      .first_err_vld(fev_g), .first_err_vec(fvec_g));

   tt_sweep_checker #(.N_IN(3), .TRUTH(GOLD), .SETTLE(3), .ORDER(0)) u_slow (
      .clk(clk), .rst_n(rst_n), .start(st_s), .stim(stim_s), .dut_o(o_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
      .first_err_vld(fev_s), .first_err_vec(fvec_s));

   logic [2:0] c_stim, c_fvec;
   logic       c_busy, c_done, c_pass, c_fev;
   logic [3:0] c_err;

   always_comb begin
      c_stim = stim_b; c_busy = busy_b; c_done = done_b; c_pass = pass_b;
      c_err  = err_b;  c_fev  = fev_b;  c_fvec = fvec_b;
      if (sel == 1) begin
         c_stim = stim_g; c_busy = busy_g; c_done = done_g; c_pass = pass_g;
         c_err  = err_g;  c_fev  = fev_g;  c_fvec = fvec_g;
      end else if (sel == 2) begin
         c_stim = stim_s; c_busy = busy_s; c_done = done_s; c_pass = pass_s;
         c_err  = err_s;  c_fev  = fev_s;  c_fvec = fvec_s;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode 0: exact expected result from the table model
   // mode 1: delayed DUT too slow for the settle time, expect failures
   task automatic run_sweep(input int s, input int settle, input bit gray,
                            input int mid, input int mode);
      int         seq[8];
      int         obs[$];
      int         exp_err;
      int         exp_first;
      bit         found;
      int         cyc;
      int         per;
      logic [7:0] truth;
      truth     = GOLD;
      exp_err   = 0;
      exp_first = 0;
      found     = 0;
      per       = settle + 1;
      for (int k = 0; k < 8; k++) begin
         seq[k] = gray ? (k ^ (k >> 1)) : k;
         if (tab[seq[k]] != truth[seq[k]]) begin
            exp_err++;
            if (!found) begin
               found     = 1;
               exp_first = seq[k];
            end
         end
      end
      sel = s;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check_val("clr_err", c_err, 0);
      check_val("clr_fev", c_fev, 0);
      check_val("start_done_low", c_done, 0);
      cyc = 0;
      while (c_busy && cyc < 400) begin
         obs.push_back(int'(c_stim));
         start = (cyc == mid);
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      check_val("busy_cycles", cyc, 8 * per);
      check_val("done_set", c_done, 1);
      for (int k = 0; k < 8; k++) begin
         int got_v;
         got_v = seq[k];
         for (int j = 0; j < per; j++) begin
            if (k * per + j >= obs.size()) got_v = -1;
            else if (obs[k * per + j] != seq[k]) got_v = obs[k * per + j];
         end
         check_val("stim_seq", got_v, seq[k]);
         if (gray && k > 0 && k * per < obs.size())
            check_val("gray_step", $countones(obs[k * per] ^ obs[(k - 1) * per]), 1);
      end
      if (mode == 0) begin
         check_val("err_cnt", c_err, exp_err);
         check_val("pass", c_pass, (exp_err == 0));
         check_val("first_vld", c_fev, found);
         check_val("first_vec", c_fvec, exp_first);
      end else begin
         check_val("slow_err_nz", (c_err > 0), 1);
         check_val("slow_pass", c_pass, 0);
      end
      repeat (2) @(negedge clk);
      check_val("done_hold", c_done, 1);
      check_val("no_restart", c_busy, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      sel   = 0;
      tab   = GOLD;
      dly   = 0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check_val("rst_stim", c_stim, 0);
         check_val("rst_busy", c_busy, 0);
         check_val("rst_done", c_done, 0);
         check_val("rst_pass", c_pass, 0);
         check_val("rst_err", c_err, 0);
         check_val("rst_fev", c_fev, 0);
         check_val("rst_fvec", c_fvec, 0);
      end
      @(negedge clk) rst_n = 1'b1;

      // golden DUT, then stuck-at-0 DUT, then a fresh golden run after failure
      run_sweep(0, 1, 0, -1, 0);
      tab = 8'h00;
      run_sweep(0, 1, 0, -1, 0);
      check_val("tied0_err5", c_err, 5);
      check_val("tied0_first", c_fvec, 1);
      tab = GOLD;
      run_sweep(0, 1, 0, -1, 0);

      // Gray order
      run_sweep(1, 1, 1, -1, 0);

      // slow DUT: adequate settle passes, minimal settle fails
      dly = 1;
      run_sweep(2, 3, 0, -1, 0);
      run_sweep(0, 1, 0, -1, 1);
      dly = 0;

      // asynchronous reset mid-sweep
      sel = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      begin
         int guard;
         guard = 0;
         while (c_stim != 3'b100 && guard < 100) begin
            guard++;
            @(negedge clk);
         end
         check_val("reach_vec4", c_stim, 4);
      end
      rst_n = 1'b0;
      #1;
      check_val("arst_stim", c_stim, 0);
      check_val("arst_busy", c_busy, 0);
      check_val("arst_done", c_done, 0);
      check_val("arst_err", c_err, 0);
      @(negedge clk) rst_n = 1'b1;
      run_sweep(0, 1, 0, -1, 0);

      // start while busy, and start coincident with final CHECK
      tab = 8'h5A;
      run_sweep(0, 1, 0, 5, 0);
      run_sweep(0, 1, 0, 15, 0);

      for (int r = 0; r < 20; r++) begin
         int s;
         tab = 8'($urandom);
         s   = int'($urandom_range(0, 2));
         run_sweep(s, (s == 2) ? 3 : 1, (s == 1), int'($urandom_range(0, 40)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
